sram_ctrl: RTL and testbench

External asynchronous SRAM interface on the 16-bit core's memory side, directly downstream of control_fsm.
- Accepts single-word read/write requests: req/we, 19-bit word address, 16-bit write data.
- Sequences the SRAM pins (ce_n, oe_n, we_n, address, data drive enable) with a programmable number of access cycles.
- Returns read data plus a one-cycle ready pulse; the top level owns the dq tristate buffer.

---
 rtl/sram_ctrl_pkg.sv | 24 ++
 rtl/sram_ctrl.sv | 132 +++++++++++++
 tb/tb_sram_ctrl.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the asynchronous SRAM controller.
package sram_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        HOLD   = 2'd3
    } state_t;

    localparam int SRAM_ADDR_W = 19;
    localparam int SRAM_DATA_W = 16;

    // Ceiling log2; returns 0 for values of 1 or less.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/sram_ctrl.sv
// Single-word asynchronous SRAM access sequencer (IDLE/SETUP/ACCESS/HOLD).
// Optional byte lanes: define SRAM_CTRL_BYTE_EN_EN to add byte_en, sram_ub_n and sram_lb_n.
module sram_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int WAIT_CYCLES = 2,
    parameter int ADDR_W      = SRAM_ADDR_W,
    parameter int DATA_W      = SRAM_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
`ifdef SRAM_CTRL_BYTE_EN_EN
    input  logic [1:0]        byte_en,
    output logic              sram_ub_n,
    output logic              sram_lb_n,
`endif
    output logic [DATA_W-1:0] rdata,
    output logic              ready,
    output logic              busy,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_dq_out,
    output logic              sram_dq_oe,
    input  logic [DATA_W-1:0] sram_dq_in,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n
);

    localparam int WAIT_EFF = (WAIT_CYCLES < 1) ? 1 : WAIT_CYCLES;
    localparam int CNT_BITS = clog2(WAIT_EFF);
    localparam int CNT_W    = (CNT_BITS < 1) ? 1 : CNT_BITS;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_EFF - 1);

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;
    logic             we_lat;
    logic             we_strobe;

`ifdef SRAM_CTRL_BYTE_EN_EN
    logic [1:0] be_lat;
    // A write with no lanes enabled still sequences but never strobes we_n.
    assign we_strobe = we_lat && (be_lat != 2'b00);
`else
    assign we_strobe = we_lat;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            we_lat      <= 1'b0;
            rdata       <= '0;
            ready       <= 1'b0;
            busy        <= 1'b0;
            sram_addr   <= '0;
            sram_dq_out <= '0;
            sram_dq_oe  <= 1'b0;
            sram_ce_n   <= 1'b1;
            sram_oe_n   <= 1'b1;
            sram_we_n   <= 1'b1;
`ifdef SRAM_CTRL_BYTE_EN_EN
            be_lat      <= 2'b00;
            sram_ub_n   <= 1'b1;
            sram_lb_n   <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE: begin
                    ready <= 1'b0;
                    if (req) begin
                        // Outputs are loaded here so they are valid throughout SETUP.
                        state       <= SETUP;
                        busy        <= 1'b1;
                        we_lat      <= we;
                        sram_ce_n   <= 1'b0;
                        sram_addr   <= addr;
                        sram_we_n   <= 1'b1;
                        sram_oe_n   <= we;
                        sram_dq_oe  <= we;
                        sram_dq_out <= we ? wdata : '0;
`ifdef SRAM_CTRL_BYTE_EN_EN
                        be_lat      <= byte_en;
                        sram_ub_n   <= we ? ~byte_en[1] : 1'b0;
                        sram_lb_n   <= we ? ~byte_en[0] : 1'b0;
`endif
                    end
                end
                SETUP: begin
                    state    <= ACCESS;
                    wait_cnt <= CNT_LOAD;
                    if (we_strobe) begin
                        sram_we_n <= 1'b0;
                    end
                end
                ACCESS: begin
                    if (wait_cnt == '0) begin
                        state     <= HOLD;
                        sram_we_n <= 1'b1;
                        sram_oe_n <= 1'b1;
                        ready     <= 1'b1;
                        if (!we_lat) begin
                            rdata <= sram_dq_in;
                        end
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                HOLD: begin
                    state       <= IDLE;
                    ready       <= 1'b0;
                    busy        <= 1'b0;
                    sram_ce_n   <= 1'b1;
                    sram_dq_oe  <= 1'b0;
                    sram_addr   <= '0;
                    sram_dq_out <= '0;
`ifdef SRAM_CTRL_BYTE_EN_EN
                    sram_ub_n   <= 1'b1;
                    sram_lb_n   <= 1'b1;
`endif
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_ctrl.sv
// Self-checking bench for sram_ctrl: SRAM pin model plus a word-level reference memory.
module tb_sram_ctrl;

    localparam int WC = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [18:0] addr = '0;
    logic [15:0] wdata = '0;
    logic [15:0] rdata;
    logic        ready;
    logic        busy;
    logic [18:0] sram_addr;
    logic [15:0] sram_dq_out;
    logic        sram_dq_oe;
    logic [15:0] sram_dq_in;
    logic        sram_ce_n;
    logic        sram_oe_n;
    logic        sram_we_n;
`ifdef SRAM_CTRL_BYTE_EN_EN
    logic [1:0]  byte_en = 2'b11;
    logic        sram_ub_n;
    logic        sram_lb_n;
`endif

    int n_cmp = 0;
    int n_err = 0;
    logic [15:0] exp_rdata = '0;
    logic [15:0] ref_mem [int];
    logic [15:0] sram_mem [0:(1<<19)-1];

    always #5 clk = ~clk;

    sram_ctrl #(.WAIT_CYCLES(WC)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
`ifdef SRAM_CTRL_BYTE_EN_EN
        .byte_en(byte_en), .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n),
`endif
        .rdata(rdata), .ready(ready), .busy(busy), .sram_addr(sram_addr),
        .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe), .sram_dq_in(sram_dq_in),
        .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n)
    );

    // Asynchronous SRAM pin model: drives dq while selected and output-enabled.
    assign sram_dq_in = (!sram_ce_n && !sram_oe_n) ? sram_mem[sram_addr] : 16'hDEAD;

    always @(negedge clk) begin
        if (!sram_ce_n && !sram_we_n && sram_dq_oe) begin
`ifdef SRAM_CTRL_BYTE_EN_EN
            if (!sram_ub_n) sram_mem[sram_addr][15:8] <= sram_dq_out[15:8];
            if (!sram_lb_n) sram_mem[sram_addr][7:0]  <= sram_dq_out[7:0];
`else
            sram_mem[sram_addr] <= sram_dq_out;
`endif
        end
    end

    function automatic logic [15:0] init_val(input logic [18:0] a);
        return a[15:0] ^ 16'h5A5A;
    endfunction

    function automatic logic [15:0] ref_read(input logic [18:0] a);
        if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
        return init_val(a);
    endfunction

    // One complete access; cycle 0 is the cycle in which req is presented.
    task automatic do_access(input logic w, input logic [18:0] a, input logic [15:0] d,
                             input logic [1:0] be, input string name);
        logic [1:0]  eff_be;
        logic [15:0] mask;
        logic [15:0] rd_val;
        logic [15:0] rd_before;
        logic [5:0]  got_s, exp_s;
        logic        act;
`ifdef SRAM_CTRL_BYTE_EN_EN
        logic [1:0]  got_l, exp_l;
        eff_be = be;
`else
        eff_be = 2'b11;
`endif
        mask      = {{8{eff_be[1]}}, {8{eff_be[0]}}};
        rd_val    = ref_read(a);
        rd_before = exp_rdata;
        @(posedge clk); #1;
        req = 1'b1; we = w; addr = a; wdata = d;
`ifdef SRAM_CTRL_BYTE_EN_EN
        byte_en = be;
`endif
        for (int k = 1; k <= WC + 3; k++) begin
            @(posedge clk); #1;
            if (k == 1) begin
                req = 1'b0; we = ~w; addr = 19'($urandom); wdata = 16'($urandom);
            end
            act   = (k <= WC + 2);
            exp_s = {!act,
                     !(!w && k <= WC + 1),
                     !(w && eff_be != 2'b00 && k >= 2 && k <= WC + 1),
                     w && act,
                     k == WC + 2,
                     act};
            got_s = {sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe, ready, busy};
            n_cmp++;
            if (got_s !== exp_s) begin
                n_err++;
                $display("FAIL %s cyc%0d ce/oe/we/dqoe/ready/busy got=%b exp=%b", name, k, got_s, exp_s);
            end
            n_cmp++;
            if (sram_addr !== (act ? a : 19'h0) || sram_dq_out !== ((w && act) ? d : 16'h0)) begin
                n_err++;
                $display("FAIL %s cyc%0d addr/dq got=%h/%h exp=%h/%h", name, k, sram_addr, sram_dq_out,
                         act ? a : 19'h0, (w && act) ? d : 16'h0);
            end
            n_cmp++;
            if (rdata !== ((!w && k >= WC + 2) ? rd_val : rd_before)) begin
                n_err++;
                $display("FAIL %s cyc%0d rdata got=%h exp=%h", name, k, rdata,
                         (!w && k >= WC + 2) ? rd_val : rd_before);
            end
`ifdef SRAM_CTRL_BYTE_EN_EN
            exp_l = !act ? 2'b11 : (w ? ~eff_be : 2'b00);
            got_l = {sram_ub_n, sram_lb_n};
            n_cmp++;
            if (got_l !== exp_l) begin
                n_err++;
                $display("FAIL %s cyc%0d ub_n/lb_n got=%b exp=%b", name, k, got_l, exp_l);
            end
`endif
        end
        if (w) ref_mem[int'(a)] = (ref_read(a) & ~mask) | (d & mask);
        else   exp_rdata = rd_val;
        $display("txn %s %s addr=%h data=%h be=%b rdata=%h", name, w ? "WR" : "RD", a, w ? d : rd_val, eff_be, rdata);
    endtask

    task automatic check_idle_outputs(input string name);
        logic [5:0] got_s;
        got_s = {sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe, ready, busy};
        n_cmp++;
        if (got_s !== 6'b111000 || sram_addr !== 19'h0 || sram_dq_out !== 16'h0 || rdata !== 16'h0) begin
            n_err++;
            $display("FAIL %s strobes=%b addr=%h dq=%h rdata=%h exp strobes=111000 rest=0",
                     name, got_s, sram_addr, sram_dq_out, rdata);
        end
`ifdef SRAM_CTRL_BYTE_EN_EN
        n_cmp++;
        if ({sram_ub_n, sram_lb_n} !== 2'b11) begin
            n_err++;
            $display("FAIL %s ub_n/lb_n got=%b exp=11", name, {sram_ub_n, sram_lb_n});
        end
`endif
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        #1 check_idle_outputs("reset_async");
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        exp_rdata = 16'h0;
        @(posedge clk); #1;
        check_idle_outputs("reset_idle");
        $display("txn reset done");
    endtask

    task automatic test_write_read();
        do_access(1'b1, 19'h12345, 16'hBEEF, 2'b11, "wr_beef");
        do_access(1'b0, 19'h12345, 16'h0000, 2'b11, "rd_beef");
        n_cmp++;
        if (rdata !== 16'hBEEF) begin
            n_err++;
            $display("FAIL rd_beef_value got=%h exp=BEEF", rdata);
        end
    endtask

    task automatic test_back_to_back();
        logic [18:0] base;
        logic [15:0] d [0:12];
        logic        exp_busy, exp_ready;
        base = 19'h40000;
        for (int j = 0; j <= 12; j++) d[j] = 16'($urandom);
        @(posedge clk); #1;
        req = 1'b1; we = 1'b1; addr = base; wdata = d[0];
        for (int k = 1; k <= 15; k++) begin
            @(posedge clk); #1;
            exp_busy  = (k % 5) != 0;
            exp_ready = (k % 5) == 4;
            n_cmp++;
            if (busy !== exp_busy || ready !== exp_ready) begin
                n_err++;
                $display("FAIL b2b cyc%0d busy/ready got=%b%b exp=%b%b", k, busy, ready, exp_busy, exp_ready);
            end
            if ((k % 5) == 1) begin
                n_cmp++;
                if (sram_ce_n !== 1'b0 || sram_addr !== base + 19'(k - 1)) begin
                    n_err++;
                    $display("FAIL b2b_start cyc%0d ce_n=%b addr got=%h exp=%h", k, sram_ce_n, sram_addr,
                             base + 19'(k - 1));
                end
            end
            if (k <= 12) begin
                addr = base + 19'(k); wdata = d[k];
            end else begin
                req = 1'b0;
            end
        end
        for (int j = 0; j <= 10; j += 5) ref_mem[int'(base + 19'(j))] = d[j];
        $display("txn b2b starts at cycles 0,5,10");
        do_access(1'b0, base,          16'h0, 2'b11, "b2b_rd0");
        do_access(1'b0, base + 19'd1,  16'h0, 2'b11, "b2b_rd1");
        do_access(1'b0, base + 19'd5,  16'h0, 2'b11, "b2b_rd5");
        do_access(1'b0, base + 19'd7,  16'h0, 2'b11, "b2b_rd7");
        do_access(1'b0, base + 19'd10, 16'h0, 2'b11, "b2b_rd10");
    endtask

    task automatic test_random();
        logic        w;
        logic [18:0] a;
        logic [1:0]  be;
        for (int i = 0; i < 24; i++) begin
            w  = 1'($urandom_range(0, 1));
            a  = 19'h00100 + 19'($urandom_range(0, 15));
            be = 2'($urandom_range(0, 3));
            do_access(w, a, 16'($urandom), be, "rand");
        end
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1;
        req = 1'b1; we = 1'b1; addr = 19'h7FFF0; wdata = 16'hC0DE;
        @(posedge clk); #1;
        req = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (sram_we_n !== 1'b0) begin
            n_err++;
            $display("FAIL rst_mid_access we_n got=%b exp=0", sram_we_n);
        end
        #1 rst = 1'b1;
        #1 exp_rdata = 16'h0;
        check_idle_outputs("rst_mid_async");
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (ready !== 1'b0 || busy !== 1'b0) begin
                n_err++;
                $display("FAIL rst_mid_quiet cyc%0d ready/busy got=%b%b exp=00", k, ready, busy);
            end
        end
        $display("txn reset during write access");
        do_access(1'b0, 19'h12345, 16'h0, 2'b11, "rst_mid_rd");
    endtask

`ifdef SRAM_CTRL_BYTE_EN_EN
    task automatic test_byte_en();
        do_access(1'b1, 19'h0ABCD, 16'hFFFF, 2'b11, "be_fill");
        do_access(1'b1, 19'h0ABCD, 16'hA55A, 2'b01, "be_low");
        do_access(1'b0, 19'h0ABCD, 16'h0,    2'b00, "be_rd1");
        n_cmp++;
        if (rdata !== 16'hFF5A) begin
            n_err++;
            $display("FAIL be_merge got=%h exp=FF5A", rdata);
        end
        do_access(1'b1, 19'h0ABCD, 16'h1234, 2'b00, "be_none");
        do_access(1'b0, 19'h0ABCD, 16'h0,    2'b11, "be_rd2");
        n_cmp++;
        if (rdata !== 16'hFF5A) begin
            n_err++;
            $display("FAIL be_none_kept got=%h exp=FF5A", rdata);
        end
    endtask
`endif

    initial begin
        for (int i = 0; i < (1 << 19); i++) sram_mem[i] = init_val(19'(i));
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_write_read();
        test_back_to_back();
        test_random();
        test_reset_mid();
`ifdef SRAM_CTRL_BYTE_EN_EN
        test_byte_en();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
